// File: rtl/kbd_pkg.sv
// kbd_pkg: shared constants for the PS/2 keyboard MMIO device.
//   - register offsets (DATA, STATUS) within the 16-byte device window
//   - bit positions of the DATA valid flag and STATUS fields
//   - receiver state enum used by ps2_rx
package kbd_pkg;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;

  localparam int DATA_VLD_BIT  = 31;
  localparam int STAT_OVF_BIT  = 8;
  localparam int STAT_BUSY_BIT = 9;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

endpackage

// File: rtl/kbd_mmio_ps2_rx.sv
// ps2_rx: PS/2 frame receiver (synchronizers, frame FSM, timeout).
// Optional build macro: KBD_PARITY_CHECK_EN (drop frames failing odd parity).
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   ps2_clk, ps2_data raw asynchronous PS/2 lines
//   o_byte            received byte, valid while o_valid is high
//   o_valid           one-cycle strobe per accepted frame
//   o_busy            receiver is mid-frame (not IDLE)
module ps2_rx
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // r_clk_sync[1:0] is the 2-flop synchronizer; [2] holds the previous
  // synchronized value for edge detection.
  logic [2:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  rx_state_e     r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [TW-1:0] r_tmo;
  logic          r_valid;

  logic w_fall, w_bit, w_tmo, w_par_ok;

  assign w_fall = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_bit  = r_dat_sync[1];
  // Abandon a partial frame once the counter has run a full window with no edge.
  assign w_tmo  = (r_state != RX_IDLE) && !w_fall && (r_tmo == TW'(TIMEOUT_CYCLES - 1));

`ifdef KBD_PARITY_CHECK_EN
  logic r_par;
  assign w_par_ok = ^{r_shift, r_par};
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_state    <= RX_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tmo      <= '0;
      r_valid    <= 1'b0;
`ifdef KBD_PARITY_CHECK_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_data};
      r_valid    <= 1'b0;

      if (r_state == RX_IDLE || w_fall) r_tmo <= '0;
      else                              r_tmo <= r_tmo + TW'(1);

      if (w_tmo) begin
        r_state <= RX_IDLE;
      end else if (w_fall) begin
        case (r_state)
          RX_IDLE: begin
            if (!w_bit) begin
              r_state   <= RX_DATA;
              r_bit_cnt <= '0;
            end
          end
          RX_DATA: begin
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= RX_PARITY;
          end
          RX_PARITY: begin
`ifdef KBD_PARITY_CHECK_EN
            r_par   <= w_bit;
`endif
            r_state <= RX_STOP;
          end
          RX_STOP: begin
            if (w_bit && w_par_ok) r_valid <= 1'b1;
            r_state <= RX_IDLE;
          end
          default: r_state <= RX_IDLE;
        endcase
      end
    end
  end

  // r_shift is stable in IDLE, so it doubles as the output byte register.
  assign o_byte  = r_shift;
  assign o_valid = r_valid;
  assign o_busy  = (r_state != RX_IDLE);

endmodule

// File: rtl/kbd_mmio.sv
// kbd_mmio: PS/2 keyboard MMIO device with a scancode FIFO.
// Optional build macro: KBD_PARITY_CHECK_EN (passed through to ps2_rx).
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   ps2_clk, ps2_data   raw PS/2 lines
//   sel_kbd, re, we     device select and CPU load/store strobes
//   addr[3:0]           byte offset (bits 3:2 decoded)
//   din[31:0]           store data (bit 8 at STATUS clears overflow)
//   dout_kbd[31:0]      combinational read data
//     0x0 DATA  : {valid, 23'0, head byte}, 0 when empty; read pops
//     0x4 STATUS: {22'0, busy, overflow, count}
//     0x8/0xC   : 0
module kbd_mmio
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        sel_kbd,
  input  logic        re,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout_kbd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic [7:0] w_rx_byte;
  logic       w_rx_valid, w_rx_busy;
  logic       w_sel_data, w_sel_stat, w_empty, w_full;
  logic       w_pop, w_push, w_ovf_set, w_ovf_clr;
  logic       w_unused_ok;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .o_byte  (w_rx_byte),
    .o_valid (w_rx_valid),
    .o_busy  (w_rx_busy)
  );

  assign w_sel_data = (addr[3:2] == OFF_DATA[3:2]);
  assign w_sel_stat = (addr[3:2] == OFF_STATUS[3:2]);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(FIFO_DEPTH));

  assign w_pop     = sel_kbd & re & w_sel_data & ~w_empty;
  // A same-cycle pop frees the head slot, so a full FIFO still accepts.
  assign w_push    = w_rx_valid & (~w_full | w_pop);
  assign w_ovf_set = w_rx_valid & w_full & ~w_pop;
  assign w_ovf_clr = sel_kbd & we & w_sel_stat & din[STAT_OVF_BIT];

  assign w_unused_ok = &{1'b0, addr[1:0], din[31:9], din[7:0]};

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_rx_byte;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  always_comb begin
    dout_kbd = 32'h0;
    if (w_sel_data) begin
      if (!w_empty) begin
        dout_kbd[DATA_VLD_BIT] = 1'b1;
        dout_kbd[7:0]          = r_mem[r_rd];
      end
    end else if (w_sel_stat) begin
      dout_kbd[7:0]           = 8'(r_count);
      dout_kbd[STAT_OVF_BIT]  = r_ovf;
      dout_kbd[STAT_BUSY_BIT] = w_rx_busy;
    end
  end

endmodule

// File: tb/tb_kbd_mmio.sv
module tb_kbd_mmio;
  localparam int DEPTH = 8;
  localparam int TMO   = 300;
  localparam int H     = 6;   // PS/2 half-period in clk cycles

  logic        clk = 1'b0;
  logic        rst_n, ps2_clk, ps2_data, sel_kbd, re, we;
  logic [3:0]  addr;
  logic [31:0] din, dout_kbd;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of stored bytes plus the overflow flag.
  logic [7:0] mq[$];
  logic       movf;

  kbd_mmio #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .sel_kbd(sel_kbd), .re(re), .we(we), .addr(addr), .din(din),
    .dout_kbd(dout_kbd)
  );

  always #5 clk = ~clk;

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  function automatic logic accepted(input logic [7:0] b, input logic p, input logic s);
`ifdef KBD_PARITY_CHECK_EN
    return s && (p == odd_par(b));
`else
    return s;
`endif
  endfunction

  function automatic void m_push(input logic [7:0] b);
    if (mq.size() < DEPTH) mq.push_back(b);
    else movf = 1'b1;
  endfunction

  function automatic logic [31:0] m_status();
    logic [7:0] c;
    c = 8'(mq.size());
    return {22'h0, 1'b0, movf, c};
  endfunction

  function automatic logic [31:0] m_data();
    if (mq.size() == 0) return 32'h0;
    return {1'b1, 23'h0, mq[0]};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    idle(H);
    ps2_clk = 1'b0;
    idle(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(s);
    ps2_data = 1'b1;
    idle(4);
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    sel_kbd = 1'b1; re = 1'b1; addr = a;
    #1 d = dout_kbd;
    @(negedge clk);
    sel_kbd = 1'b0; re = 1'b0; addr = 4'h0;
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [31:0] v);
    @(negedge clk);
    sel_kbd = 1'b1; we = 1'b1; addr = a; din = v;
    @(negedge clk);
    sel_kbd = 1'b0; we = 1'b0; addr = 4'h0; din = 32'h0;
  endtask

  task automatic drain(input string tag);
    logic [31:0] d, e;
    while (mq.size() > 0) begin
      e = m_data();
      cpu_rd(4'h0, d);
      void'(mq.pop_front());
      total++;
      if (d !== e) begin bad++; $display("FAIL %s drain got=%h exp=%h", tag, d, e); end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    idle(3);
    rst_n = 1'b1;
    mq.delete(); movf = 1'b0;
    idle(2);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [3:0] offs [4];
    offs = '{4'h0, 4'h4, 4'h8, 4'hC};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cpu_rd(offs[i], d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL reset off=%h got=%h exp=0", offs[i], d); end
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    send_frame(8'h1C, 1'b0, 1'b1);
    m_push(8'h1C);
    cpu_rd(4'h4, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL basic status got=%h exp=00000001", d); end
    cpu_rd(4'h8, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL basic off8 got=%h exp=0", d); end
    cpu_rd(4'h0, d);
    void'(mq.pop_front());
    total++;
    if (d !== 32'h8000001C) begin bad++; $display("FAIL basic data got=%h exp=8000001c", d); end
    cpu_rd(4'h0, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL basic empty got=%h exp=0", d); end
  endtask

  task automatic test_parity();
    logic [31:0] d;
    logic [7:0] b;
    logic p, s;
    send_frame(8'h1C, 1'b1, 1'b1);
    if (accepted(8'h1C, 1'b1, 1'b1)) m_push(8'h1C);
    cpu_rd(4'h4, d);
    total++;
    if (d !== m_status()) begin bad++; $display("FAIL parity status got=%h exp=%h", d, m_status()); end
    drain("parity1c");
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      p = ($urandom_range(0, 1) == 1) ? odd_par(b) : ~odd_par(b);
      s = ($urandom_range(0, 3) != 0);
      send_frame(b, p, s);
      if (accepted(b, p, s)) m_push(b);
      cpu_rd(4'h4, d);
      total++;
      if (d !== m_status()) begin bad++; $display("FAIL parity_rand status got=%h exp=%h", d, m_status()); end
    end
    drain("parity_rand");
  endtask

  task automatic test_random();
    logic [31:0] d, e;
    logic [7:0] b;
    for (int k = 0; k < 10; k++) begin
      b = 8'($urandom);
      send_frame(b, odd_par(b), 1'b1);
      m_push(b);
      if ($urandom_range(0, 1) == 1) begin
        e = m_data();
        cpu_rd(4'h0, d);
        if (mq.size() > 0) void'(mq.pop_front());
        total++;
        if (d !== e) begin bad++; $display("FAIL random data got=%h exp=%h", d, e); end
      end
    end
    cpu_rd(4'h4, d);
    total++;
    if (d !== m_status()) begin bad++; $display("FAIL random status got=%h exp=%h", d, m_status()); end
    drain("random");
    cpu_rd(4'h0, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL random empty got=%h exp=0", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [7:0] b;
    for (int k = 1; k <= 9; k++) begin
      b = 8'(k);
      send_frame(b, odd_par(b), 1'b1);
      m_push(b);
    end
    cpu_rd(4'h4, d);
    total++;
    if (d !== 32'h108) begin bad++; $display("FAIL ovf status got=%h exp=00000108", d); end
    cpu_wr(4'h4, 32'hFFFF_FEFF);  // bit 8 clear: must not clear overflow
    cpu_wr(4'h0, 32'h100);        // wrong offset: ignored
    cpu_rd(4'h4, d);
    total++;
    if (d !== m_status()) begin bad++; $display("FAIL ovf keep got=%h exp=%h", d, m_status()); end
    drain("ovf");
    cpu_rd(4'h4, d);
    total++;
    if (d !== 32'h100) begin bad++; $display("FAIL ovf sticky got=%h exp=00000100", d); end
    cpu_wr(4'h4, 32'h100);
    movf = 1'b0;
    cpu_rd(4'h4, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL ovf clear got=%h exp=0", d); end
  endtask

  task automatic test_full_pop();
    logic [31:0] d, e;
    logic [7:0] b;
    bit seen;
    for (int k = 0; k < DEPTH; k++) begin
      b = 8'($urandom);
      send_frame(b, odd_par(b), 1'b1);
      m_push(b);
    end
    b = 8'($urandom);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(odd_par(b));
    ps2_data = 1'b1;
    idle(H);
    ps2_clk = 1'b0;
    seen = 1'b0;
    e = m_data();
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (dut.u_rx.o_valid) begin
        seen = 1'b1;
        sel_kbd = 1'b1; re = 1'b1; addr = 4'h0;
        #1 d = dout_kbd;
        @(negedge clk);
        sel_kbd = 1'b0; re = 1'b0;
      end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL fullpop no push strobe within bound"); end
    total++;
    if (seen && d !== e) begin bad++; $display("FAIL fullpop popped got=%h exp=%h", d, e); end
    void'(mq.pop_front());
    mq.push_back(b);
    idle(H);
    ps2_clk = 1'b1;
    idle(4);
    cpu_rd(4'h4, d);
    total++;
    if (d !== 32'h8) begin bad++; $display("FAIL fullpop status got=%h exp=00000008", d); end
    e = {1'b1, 23'h0, b};
    drain("fullpop");
    total++;
    if (dout_kbd !== dout_kbd || e[7:0] !== b) begin bad++; end
    cpu_rd(4'h4, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL fullpop end status got=%h exp=0", d); end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    idle(2);
    cpu_rd(4'h4, d);
    total++;
    if (d !== 32'h200) begin bad++; $display("FAIL tmo busy got=%h exp=00000200", d); end
    idle(TMO + 1);
    cpu_rd(4'h4, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL tmo idle got=%h exp=0", d); end
    send_frame(8'hF0, odd_par(8'hF0), 1'b1);
    cpu_rd(4'h0, d);
    total++;
    if (d !== 32'h800000F0) begin bad++; $display("FAIL tmo next got=%h exp=800000f0", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [7:0] b;
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      send_frame(b, odd_par(b), 1'b1);
      m_push(b);
    end
    cpu_rd(4'h4, d);
    total++;
    if (d !== 32'h3) begin bad++; $display("FAIL rstmid pre got=%h exp=00000003", d); end
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    do_reset();
    cpu_rd(4'h4, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rstmid status got=%h exp=0", d); end
    idle(40);
    cpu_rd(4'h0, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rstmid data got=%h exp=0", d); end
  endtask

  initial begin
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    sel_kbd = 1'b0; re = 1'b0; we = 1'b0; addr = 4'h0; din = 32'h0;
    movf = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_random();
    test_overflow();
    test_full_pop();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
